// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: pattern type, the hex encode table (bits g..a),
// the blank pattern, the decoder result payload and the encode helper used by
// the hex-to-7-segment encoder.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    typedef struct packed {
        logic       legal;
        logic       blank;
        logic [3:0] nibble;
    } seg7_decode_t;

    localparam seg7_t SEG7_BLANK = 7'b0000000;

    // Index = hex value, entry = segments g..a lit for that value.
    localparam seg7_t SEG7_TABLE [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b1011000, 7'b1011110, 7'b1111001, 7'b1110001
    };

    // Forward mapping shared with the encoder so both directions use one table.
    function automatic seg7_t seg7_encode(input logic [3:0] nibble);
        return SEG7_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern decoder: searches SEG7_TABLE for the pattern.
// Ports:
//   pattern  in   segment pattern, bit0 = a .. bit6 = g (active-high)
//   result   out  {legal, blank, nibble}; nibble is 0 when not legal
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  seg7_t        pattern,
    output seg7_decode_t result
);

    // First table hit wins; table entries are unique so order does not matter.
    always_comb begin
        result        = '0;
        result.blank  = (pattern == SEG7_BLANK);
        for (int unsigned i = 0; i < 16; i++) begin
            if (!result.legal && (pattern == SEG7_TABLE[4'(i)])) begin
                result.legal  = 1'b1;
                result.nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_capture_decoder.sv
// Captures a time-multiplexed 7-segment bus, debounces each sample, and decodes
// the displayed pattern back to a hex nibble per digit. Flags frame completion
// and illegal patterns.
// Optional feature macro: SEG7_CAP_DP_EN (adds dp_in / dp_vec decimal point capture).
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   seg_in      segment pattern, bit0 = a .. bit6 = g
//   digit_sel   one-hot select of the digit currently driven
//   negate      1 = active-low segments (inverted before compare/decode)
//   dp_in       decimal point input (SEG7_CAP_DP_EN only)
//   dp_vec      captured decimal point per digit (SEG7_CAP_DP_EN only)
//   hex_vec     recovered nibbles, digit i at [i*4 +: 4]
//   valid_vec   bit i = digit i holds a decoded value
//   frame_done  one-cycle pulse when all digits accepted since last pulse
//   err         one-cycle pulse when an illegal pattern is accepted
//   err_digit   index of the digit that raised the last err
module seg7_capture_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS        = 6,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic [DIGITS-1:0]       digit_sel,
    input  logic                    negate,
`ifdef SEG7_CAP_DP_EN
    input  logic                    dp_in,
    output logic [DIGITS-1:0]       dp_vec,
`endif
    output logic [DIGITS*4-1:0]     hex_vec,
    output logic [DIGITS-1:0]       valid_vec,
    output logic                    frame_done,
    output logic                    err,
    output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] err_digit
);

    localparam int unsigned ERR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
`ifdef SEG7_CAP_DP_EN
    localparam int unsigned SAMP_W = 8 + DIGITS;
`else
    localparam int unsigned SAMP_W = 7 + DIGITS;
`endif

    logic [SAMP_W-1:0]   cur_c;
    logic [SAMP_W-1:0]   sample_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                accepted_q, accepted_d;
    logic [DIGITS-1:0]   seen_q, seen_d, seen_upd_c;
    logic [DIGITS-1:0]   sample_sel_c;
    seg7_t               sample_seg_c;
    seg7_decode_t        dec_c;
    logic [ERR_W-1:0]    sel_idx_c;
    logic                onehot_c, same_c, accept_c;
    logic [DIGITS*4-1:0] hex_d;
    logic [DIGITS-1:0]   valid_d;
    logic                frame_done_d, err_d;
    logic [ERR_W-1:0]    err_digit_d;
`ifdef SEG7_CAP_DP_EN
    logic [DIGITS-1:0]   dp_d;
`endif

    // Polarity-normalised sample vector; digit select sits in the low bits.
`ifdef SEG7_CAP_DP_EN
    assign cur_c = {dp_in ^ negate, seg_in ^ {7{negate}}, digit_sel};
`else
    assign cur_c = {seg_in ^ {7{negate}}, digit_sel};
`endif

    assign sample_sel_c = sample_q[DIGITS-1:0];
    assign sample_seg_c = sample_q[DIGITS +: 7];
    assign same_c       = (cur_c == sample_q);
    assign onehot_c     = (sample_sel_c != '0) &&
                          ((sample_sel_c & (sample_sel_c - DIGITS'(1))) == '0);
    assign accept_c     = (cnt_q == CNT_W'(STABLE_CYCLES)) && !accepted_q && onehot_c;

    seg7_pattern_decode u_decode (
        .pattern (sample_seg_c),
        .result  (dec_c)
    );

    // Binary index of the selected digit (only meaningful when one-hot).
    always_comb begin
        sel_idx_c = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (sample_sel_c[i]) sel_idx_c = ERR_W'(i);
        end
    end

    // Debounce counter, acceptance, seen mask and next output values.
    always_comb begin
        cnt_d        = cnt_q;
        accepted_d   = accepted_q;
        seen_d       = seen_q;
        seen_upd_c   = seen_q | sample_sel_c;
        hex_d        = hex_vec;
        valid_d      = valid_vec;
        frame_done_d = 1'b0;
        err_d        = 1'b0;
        err_digit_d  = err_digit;
`ifdef SEG7_CAP_DP_EN
        dp_d         = dp_vec;
`endif

        // A new sample value starts a new run, which is eligible for acceptance again.
        if (same_c) begin
            if (cnt_q != CNT_W'(STABLE_CYCLES)) cnt_d = cnt_q + CNT_W'(1);
            accepted_d = accepted_q | accept_c;
        end else begin
            cnt_d      = CNT_W'(1);
            accepted_d = 1'b0;
        end

        if (accept_c) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
                if (sample_sel_c[i]) begin
                    valid_d[i] = dec_c.legal;
                    if (dec_c.legal) hex_d[i*4 +: 4] = dec_c.nibble;
`ifdef SEG7_CAP_DP_EN
                    dp_d[i] = sample_q[SAMP_W-1];
`endif
                end
            end
            if (!dec_c.legal && !dec_c.blank) begin
                err_d       = 1'b1;
                err_digit_d = sel_idx_c;
            end
            if (&seen_upd_c) begin
                frame_done_d = 1'b1;
                seen_d       = '0;
            end else begin
                seen_d = seen_upd_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q   <= '0;
            cnt_q      <= '0;
            accepted_q <= 1'b0;
            seen_q     <= '0;
            hex_vec    <= '0;
            valid_vec  <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            err_digit  <= '0;
`ifdef SEG7_CAP_DP_EN
            dp_vec     <= '0;
`endif
        end else begin
            sample_q   <= cur_c;
            cnt_q      <= cnt_d;
            accepted_q <= accepted_d;
            seen_q     <= seen_d;
            hex_vec    <= hex_d;
            valid_vec  <= valid_d;
            frame_done <= frame_done_d;
            err        <= err_d;
            err_digit  <= err_digit_d;
`ifdef SEG7_CAP_DP_EN
            dp_vec     <= dp_d;
`endif
        end
    end

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Self-checking bench for seg7_capture_decoder (DIGITS=6, STABLE_CYCLES=4).
module tb_seg7_capture_decoder;

    localparam int unsigned DIGITS = 6;
    localparam int unsigned STABLE = 4;

    typedef struct packed {
        logic [23:0] hex;
        logic [5:0]  valid;
        logic        fd;
        logic        err;
        logic [2:0]  errd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_in;
    logic [5:0]  digit_sel;
    logic        negate;
    logic [23:0] hex_vec;
    logic [5:0]  valid_vec;
    logic        frame_done;
    logic        err;
    logic [2:0]  err_digit;
`ifdef SEG7_CAP_DP_EN
    logic        dp_in = 1'b0;
    logic [5:0]  dp_vec;
`endif

    always #5 clk = ~clk;

    seg7_capture_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_in     (seg_in),
        .digit_sel  (digit_sel),
        .negate     (negate),
`ifdef SEG7_CAP_DP_EN
        .dp_in      (dp_in),
        .dp_vec     (dp_vec),
`endif
        .hex_vec    (hex_vec),
        .valid_vec  (valid_vec),
        .frame_done (frame_done),
        .err        (err),
        .err_digit  (err_digit)
    );

    // Encode table, bits g..a, indexed by hex value.
    logic [6:0] tbl [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b1011000, 7'b1011110, 7'b1111001, 7'b1110001
    };

    int vectors     = 0;
    int miscompares = 0;
    int fd_count    = 0;
    int err_count   = 0;
    exp_t sb_q[$];

    // Reference model state: last sample and length of the current identical run.
    logic [12:0] m_prev;
    int          m_run;
    logic [23:0] m_hex;
    logic [5:0]  m_valid;
    logic [5:0]  m_seen;
    logic [2:0]  m_errd;

    // Drive one clock of stimulus, push the model's prediction, compare after the edge.
    task automatic step(input logic r, input logic [6:0] s, input logic [5:0] sel, input logic n);
        exp_t        e;
        exp_t        got;
        logic [12:0] cur;
        logic [6:0]  p;
        logic [5:0]  seen_n;
        int          nib;
        int          d;
        rst = r; seg_in = s; digit_sel = sel; negate = n;
        e.fd = 1'b0; e.err = 1'b0;
        if (r) begin
            m_prev = '0; m_run = 0; m_hex = '0; m_valid = '0; m_seen = '0; m_errd = '0;
        end else begin
            cur = {s ^ {7{n}}, sel};
            if (m_run == STABLE && $countones(m_prev[5:0]) == 1) begin
                p = m_prev[12:6];
                nib = -1;
                for (int k = 0; k < 16; k++) if (tbl[k] == p) nib = k;
                d = 0;
                for (int k = 0; k < 6; k++) if (m_prev[k]) d = k;
                if (nib >= 0) begin
                    m_hex[d*4 +: 4] = 4'(nib);
                    m_valid[d] = 1'b1;
                end else begin
                    m_valid[d] = 1'b0;
                    if (p != 7'd0) begin
                        e.err  = 1'b1;
                        m_errd = 3'(d);
                    end
                end
                seen_n = m_seen | m_prev[5:0];
                if (seen_n == 6'h3F) begin
                    e.fd = 1'b1;
                    m_seen = '0;
                end else begin
                    m_seen = seen_n;
                end
            end
            if (cur == m_prev) m_run++;
            else m_run = 1;
            m_prev = cur;
        end
        e.hex = m_hex; e.valid = m_valid; e.errd = m_errd;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e   = sb_q.pop_front();
        got = {hex_vec, valid_vec, frame_done, err, err_digit};
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL scoreboard t=%0t got hex=%h valid=%h fd=%b err=%b errd=%0d exp hex=%h valid=%h fd=%b err=%b errd=%0d",
                     $time, got.hex, got.valid, got.fd, got.err, got.errd,
                     e.hex, e.valid, e.fd, e.err, e.errd);
        end
        if (frame_done === 1'b1) fd_count++;
        if (err === 1'b1) err_count++;
    endtask

    task automatic do_reset();
        step(1'b1, 7'd0, 6'd0, 1'b0);
        step(1'b1, 7'd0, 6'd0, 1'b0);
        fd_count = 0;
        err_count = 0;
    endtask

    task automatic test_reset();
        step(1'b0, tbl[4], 6'b000001, 1'b0);
        do_reset();
        vectors++;
        if ({hex_vec, valid_vec, frame_done, err, err_digit} !== 35'd0) begin
            miscompares++;
            $display("FAIL reset_state got hex=%h valid=%h fd=%b err=%b errd=%0d exp all 0",
                     hex_vec, valid_vec, frame_done, err, err_digit);
        end
    endtask

    task automatic test_single_digit();
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 7'b1011011, 6'b000001, 1'b0);
            if (i == 4) begin
                vectors++;
                if (valid_vec[0] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL single_early got valid0=%b exp 0", valid_vec[0]);
                end
            end
            if (i == 5) begin
                vectors++;
                if ({valid_vec[0], hex_vec[3:0]} !== 5'h12) begin
                    miscompares++;
                    $display("FAIL single_edge5 got valid0=%b hex0=%h exp valid0=1 hex0=2",
                             valid_vec[0], hex_vec[3:0]);
                end
            end
        end
        vectors++;
        if (err_count != 0) begin
            miscompares++;
            $display("FAIL single_err got %0d err pulses exp 0", err_count);
        end
    endtask

    task automatic test_scan_negate();
        do_reset();
        for (int d = 0; d < 6; d++) begin
            for (int c = 0; c < 6; c++) begin
                step(1'b0, ~tbl[d+1], 6'(1) << d, 1'b1);
                if (d == 5 && c == 4) begin
                    vectors++;
                    if (frame_done !== 1'b1) begin
                        miscompares++;
                        $display("FAIL scan_fd_edge got fd=%b exp 1", frame_done);
                    end
                end
            end
        end
        vectors++;
        if ({hex_vec, valid_vec} !== {24'h654321, 6'h3F}) begin
            miscompares++;
            $display("FAIL scan_values got hex=%h valid=%h exp hex=654321 valid=3f", hex_vec, valid_vec);
        end
        vectors++;
        if (fd_count != 1) begin
            miscompares++;
            $display("FAIL scan_fd_count got %0d exp 1", fd_count);
        end
    endtask

    task automatic test_toggle();
        logic [6:0] pat;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            pat = (((i / 3) % 2) == 1) ? tbl[5] : tbl[3];
            step(1'b0, pat, 6'b000001, 1'b0);
        end
        vectors++;
        if ({hex_vec, valid_vec, err_count, fd_count} !== {24'h0, 6'h0, 32'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL toggle got hex=%h valid=%h errs=%0d fds=%0d exp all 0",
                     hex_vec, valid_vec, err_count, fd_count);
        end
    endtask

    task automatic test_illegal_blank();
        int errs_before;
        do_reset();
        for (int c = 0; c < 6; c++) step(1'b0, tbl[7], 6'b000100, 1'b0);
        for (int c = 0; c < 6; c++) begin
            step(1'b0, 7'b1010101, 6'b000100, 1'b0);
            if (c == 4) begin
                vectors++;
                if ({err, err_digit, valid_vec[2], hex_vec[11:8]} !== {1'b1, 3'd2, 1'b0, 4'h7}) begin
                    miscompares++;
                    $display("FAIL illegal got err=%b errd=%0d valid2=%b hex2=%h exp err=1 errd=2 valid2=0 hex2=7",
                             err, err_digit, valid_vec[2], hex_vec[11:8]);
                end
            end
        end
        errs_before = err_count;
        for (int c = 0; c < 6; c++) step(1'b0, 7'b0000000, 6'b000100, 1'b0);
        vectors++;
        if ({err_count == errs_before, valid_vec[2], hex_vec[11:8], err_digit} !== {1'b1, 1'b0, 4'h7, 3'd2}) begin
            miscompares++;
            $display("FAIL blank got new_errs=%0d valid2=%b hex2=%h errd=%0d exp new_errs=0 valid2=0 hex2=7 errd=2",
                     err_count - errs_before, valid_vec[2], hex_vec[11:8], err_digit);
        end
    endtask

    task automatic test_multihot();
        do_reset();
        for (int c = 0; c < 20; c++) step(1'b0, tbl[8], 6'b000011, 1'b0);
        vectors++;
        if ({valid_vec, err_count} !== {6'h0, 32'd0}) begin
            miscompares++;
            $display("FAIL multihot got valid=%h errs=%0d exp valid=0 errs=0", valid_vec, err_count);
        end
        for (int c = 0; c < 5; c++) begin
            step(1'b0, tbl[8], 6'b000010, 1'b0);
            if (c == 3) begin
                vectors++;
                if (valid_vec[1] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL multihot_early got valid1=%b exp 0", valid_vec[1]);
                end
            end
        end
        vectors++;
        if ({valid_vec[1], hex_vec[7:4]} !== 5'h18) begin
            miscompares++;
            $display("FAIL multihot_accept got valid1=%b hex1=%h exp valid1=1 hex1=8", valid_vec[1], hex_vec[7:4]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int d = 0; d < 6; d++)
            for (int c = 0; c < 6; c++) step(1'b0, tbl[d+9], 6'(1) << d, 1'b0);
        for (int d = 0; d < 3; d++)
            for (int c = 0; c < 6; c++) step(1'b0, tbl[d], 6'(1) << d, 1'b0);
        step(1'b1, tbl[3], 6'b001000, 1'b0);
        vectors++;
        if ({hex_vec, valid_vec, frame_done, err, err_digit} !== 35'd0) begin
            miscompares++;
            $display("FAIL reset_mid got hex=%h valid=%h fd=%b err=%b errd=%0d exp all 0",
                     hex_vec, valid_vec, frame_done, err, err_digit);
        end
        fd_count = 0;
        for (int d = 0; d < 6; d++)
            for (int c = 0; c < 6; c++) step(1'b0, tbl[15-d], 6'(1) << d, 1'b0);
        vectors++;
        if (fd_count != 1) begin
            miscompares++;
            $display("FAIL reset_mid_fd got %0d frame pulses exp 1", fd_count);
        end
        vectors++;
        if ({hex_vec, valid_vec} !== {24'hABCDEF, 6'h3F}) begin
            miscompares++;
            $display("FAIL reset_mid_values got hex=%h valid=%h exp hex=abcdef valid=3f", hex_vec, valid_vec);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_digit();
        test_scan_negate();
        test_toggle();
        test_illegal_blank();
        test_multihot();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
